// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-decode arbiter: default sizes and the
// reference Gray-to-binary conversion used by both the datapath and the bench.
package gray_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int W_DEF     = 4;
  localparam int MAX_W     = 32;

  // Leading zeros of a zero-extended Gray word decode to zeros, so one
  // MAX_W-wide function serves every narrower width by truncating the result.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b = '0;
    b[MAX_W-1] = g[MAX_W-1];
    for (int k = MAX_W - 2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_w.sv
// Combinational W-bit Gray-to-binary converter; the single shared datapath
// that the arbiter time-multiplexes among requesters.
module gray2bin_w
  import gray_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  assign bin = W'(gray2bin(MAX_W'(gray)));

endmodule

// File: rtl/gray_decode_arbiter.sv
// Round-robin arbiter sharing one Gray-to-binary converter among N_REQ
// requesters, with a single registered response slot tagged by requester ID.
module gray_decode_arbiter
  import gray_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF,
  localparam int IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_gray,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  output logic [W-1:0]       rsp_bin,
  output logic [IDW-1:0]     rsp_id,
  input  logic               rsp_ready
);

  logic [IDW-1:0] rr_ptr_r;
  logic           rsp_valid_r;
  logic [W-1:0]   rsp_bin_r;
  logic [IDW-1:0] rsp_id_r;

  logic           slot_free_s;
  logic           grant_hit_s;
  logic [IDW-1:0] grant_id_s;
  logic [IDW-1:0] next_ptr_s;
  logic           accept_s;
  logic [W-1:0]   sel_gray_s;
  logic [W-1:0]   conv_bin_s;

  assign slot_free_s = ~rsp_valid_r | rsp_ready;

  // Cyclic find-first search starting at rr_ptr.
  always_comb begin
    grant_hit_s = 1'b0;
    grant_id_s  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      int idx;
      idx = (int'(rr_ptr_r) + i) % N_REQ;
      if (!grant_hit_s && req_valid[idx]) begin
        grant_hit_s = 1'b1;
        grant_id_s  = IDW'(idx);
      end else begin
        grant_hit_s = grant_hit_s;
      end
    end
  end

  // Steer the granted requester's word into the shared converter.
  always_comb begin
    sel_gray_s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (k == int'(grant_id_s)) begin
        sel_gray_s = req_gray[k*W +: W];
      end else begin
        sel_gray_s = sel_gray_s;
      end
    end
  end

  // One-hot accept, suppressed while the slot is occupied or reset is held.
  always_comb begin
    req_ready = '0;
    if (grant_hit_s && slot_free_s && rst_n) begin
      req_ready[grant_id_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  assign accept_s   = grant_hit_s & slot_free_s;
  assign next_ptr_s = IDW'((int'(grant_id_s) + 1) % N_REQ);

  gray2bin_w #(.W(W)) u_conv (
    .gray (sel_gray_s),
    .bin  (conv_bin_s)
  );

  // Response slot and round-robin pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r    <= '0;
      rsp_valid_r <= 1'b0;
      rsp_bin_r   <= '0;
      rsp_id_r    <= '0;
    end else if (accept_s) begin
      rr_ptr_r    <= next_ptr_s;
      rsp_valid_r <= 1'b1;
      rsp_bin_r   <= conv_bin_s;
      rsp_id_r    <= grant_id_s;
    end else if (rsp_valid_r && rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end else begin
      rsp_valid_r <= rsp_valid_r;
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_bin   = rsp_bin_r;
  assign rsp_id    = rsp_id_r;

endmodule

// File: tb/tb_gray_decode_arbiter.sv
// Directed self-checking bench for gray_decode_arbiter (N_REQ=4, W=4).
module tb_gray_decode_arbiter;
  import gray_pkg::*;

  localparam int N_REQ = 4;
  localparam int W     = 4;
  localparam int IDW   = 2;

  logic               clk;
  logic               rst_n;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_gray;
  logic [N_REQ-1:0]   req_ready;
  logic               rsp_valid;
  logic [W-1:0]       rsp_bin;
  logic [IDW-1:0]     rsp_id;
  logic               rsp_ready;

  int n_checks;
  int n_fail;

  gray_decode_arbiter #(.N_REQ(N_REQ), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_gray  (req_gray),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_bin   (rsp_bin),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic [3:0] bin, input logic [1:0] id);
    check_eq({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check_eq({tag, "_bin"}, 32'(rsp_bin), 32'(bin));
    check_eq({tag, "_id"}, 32'(rsp_id), 32'(id));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  logic [3:0] t2_gray [4];
  logic [3:0] t2_bin  [4];
  logic [31:0] ref_bin;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_gray  = 16'h0000;
    rsp_ready = 1'b1;
    t2_gray = '{4'b0010, 4'b1011, 4'b0110, 4'b1111};
    t2_bin  = '{4'b0011, 4'b1101, 4'b0100, 4'b1010};

    // Reset state, with requests present to show req_ready is held low.
    #12;
    check_eq("rst_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_bin", 32'(rsp_bin), 32'd0);
    check_eq("rst_id", 32'(rsp_id), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    req_valid = 4'b0000;
    tick();
    rst_n = 1'b1;

    // Single requester.
    req_valid = 4'b0001;
    req_gray[3:0] = 4'b1001;
    #1;
    check_eq("t1_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0000;
    check_rsp("t1", 4'b1110, 2'd0);

    // All four requesting from a fresh pointer.
    do_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) req_gray[k*4 +: 4] = t2_gray[k];
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq($sformatf("t2_ready%0d", k), 32'(req_ready), 32'(1) << k);
      tick();
      req_valid[k] = 1'b0;
      check_rsp($sformatf("t2_rsp%0d", k), t2_bin[k], 2'(k));
    end

    // Rotation: after id2, requesters 0 and 3 -> id3 first.
    req_valid = 4'b0100;
    req_gray[11:8] = 4'b0110;
    #1;
    check_eq("t3_ready2", 32'(req_ready), 32'b0100);
    tick();
    check_rsp("t3_rsp2", 4'b0100, 2'd2);
    req_valid = 4'b1001;
    req_gray[3:0]   = 4'b0001;
    req_gray[15:12] = 4'b1000;
    #1;
    check_eq("t3_ready3", 32'(req_ready), 32'b1000);
    tick();
    req_valid[3] = 1'b0;
    check_rsp("t3_rsp3", 4'b1111, 2'd3);
    #1;
    check_eq("t3_ready0", 32'(req_ready), 32'b0001);
    tick();
    req_valid[0] = 1'b0;
    check_rsp("t3_rsp0", 4'b0001, 2'd0);
    tick();
    check_eq("t3_drain", 32'(rsp_valid), 32'd0);

    // Backpressure.
    req_valid = 4'b0001;
    req_gray[3:0] = 4'b1001;
    rsp_ready = 1'b0;
    #1;
    check_eq("t4_ready0", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0010;
    req_gray[7:4] = 4'b0101;
    for (int c = 0; c < 5; c++) begin
      #1;
      check_eq($sformatf("t4_block%0d", c), 32'(req_ready), 32'd0);
      check_rsp($sformatf("t4_hold%0d", c), 4'b1110, 2'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check_eq("t4_ready1", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b0000;
    check_rsp("t4_rsp1", 4'b0110, 2'd1);

    // Reset mid-flight with a held response and pending requests.
    rsp_ready = 1'b0;
    req_valid = 4'b1100;
    req_gray[11:8]  = 4'b0011;
    req_gray[15:12] = 4'b1100;
    rst_n = 1'b0;
    #1;
    check_eq("t5_valid", 32'(rsp_valid), 32'd0);
    check_eq("t5_bin", 32'(rsp_bin), 32'd0);
    check_eq("t5_id", 32'(rsp_id), 32'd0);
    check_eq("t5_ready_rst", 32'(req_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    check_eq("t5_ready2", 32'(req_ready), 32'b0100);
    tick();
    req_valid[2] = 1'b0;
    check_rsp("t5_rsp2", 4'b0010, 2'd2);
    #1;
    check_eq("t5_ready3", 32'(req_ready), 32'b1000);
    tick();
    req_valid[3] = 1'b0;
    check_rsp("t5_rsp3", 4'b1000, 2'd3);

    // Exhaustive conversion through requester 3.
    for (int g = 0; g < 16; g++) begin
      req_valid = 4'b1000;
      req_gray[15:12] = 4'(g);
      #1;
      check_eq($sformatf("t6_ready_g%0d", g), 32'(req_ready), 32'b1000);
      tick();
      req_valid = 4'b0000;
      ref_bin = gray2bin(32'(g));
      check_eq($sformatf("t6_bin_g%0d", g), 32'(rsp_bin), ref_bin);
      check_eq($sformatf("t6_id_g%0d", g), 32'(rsp_id), 32'd3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
